// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM pipeline stage with variable-latency memory handshake (optional MEM_ALIGN_CHECK_EN)
//
// Drives one data-memory request per instruction, holds the request stable
// while the memory is not ready, stalls upstream for the duration and
// registers the results into the MEM/WB pipeline register.
// Define MEM_ALIGN_CHECK_EN to treat odd addresses as a fatal misaligned access.

module memory_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluOut,
  input  logic [15:0] reg2Data,
  input  logic [15:0] setVal,
  input  logic [15:0] nextPc,
  input  logic        memEn,
  input  logic        memWrt,
  input  logic        regWrt,
  input  logic [2:0]  regWrtSrc,
  input  logic [2:0]  writeReg,
  input  logic        halt,
  input  logic        errIn,
  output logic        memReq,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] memWrData,
  input  logic [15:0] memRdData,
  input  logic        memReady,
  output logic        stall,
  output logic [15:0] readDataOut,
  output logic [15:0] aluOutOut,
  output logic [15:0] setValOut,
  output logic [15:0] nextPcOut,
  output logic        regWrtOut,
  output logic        haltOut,
  output logic        err,
  output logic [2:0]  regWrtSrcOut,
  output logic [2:0]  writeRegOut
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state, nState;
  logic [7:0]  waitCnt, nWaitCnt;

  // Holding registers: the instruction that is waiting on memory
  logic [15:0] hAddr, hData, hSetVal, hNextPc;
  logic        hWr, hRegWrt, hHalt;
  logic [2:0]  hRegWrtSrc, hWriteReg;
  logic        captureHold;

  // Next values of the MEM/WB register
  logic [15:0] nReadData, nAluOut, nSetVal, nNextPc;
  logic        nRegWrt, nHalt;
  logic [2:0]  nRegWrtSrc, nWriteReg;
  logic        internalErr;
  logic        misaligned;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = memEn & aluOut[0];
`else
  assign misaligned = 1'b0;
`endif

  // Next-state, memory request, stall and MEM/WB next values
  always_comb begin
    nState      = state;
    nWaitCnt    = waitCnt;
    memReq      = 1'b0;
    memWr       = 1'b0;
    memAddr     = 16'h0000;
    memWrData   = 16'h0000;
    stall       = 1'b0;
    captureHold = 1'b0;
    internalErr = 1'b0;
    // Default MEM/WB update is a bubble: data held, control cleared
    nReadData   = readDataOut;
    nAluOut     = aluOutOut;
    nSetVal     = setValOut;
    nNextPc     = nextPcOut;
    nRegWrtSrc  = regWrtSrcOut;
    nWriteReg   = writeRegOut;
    nRegWrt     = 1'b0;
    nHalt       = 1'b0;

    case (state)
      S_IDLE: begin
        if (misaligned) begin
          internalErr = 1'b1;
          nHalt       = 1'b1;
          nState      = S_ERR;
        end else begin
          if (memEn) begin
            memReq    = 1'b1;
            memWr     = memWrt;
            memAddr   = aluOut;
            memWrData = reg2Data;
          end
          if (!memEn || memReady) begin
            nAluOut    = aluOut;
            nSetVal    = setVal;
            nNextPc    = nextPc;
            nRegWrt    = regWrt;
            nRegWrtSrc = regWrtSrc;
            nWriteReg  = writeReg;
            nHalt      = halt;
            nReadData  = (memEn && !memWrt) ? memRdData : 16'h0000;
            if (halt) nState = S_HALT;
          end else begin
            // Request not accepted this cycle: park the instruction
            stall       = 1'b1;
            captureHold = 1'b1;
            nWaitCnt    = 8'd1;
            nState      = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        memReq    = 1'b1;
        memWr     = hWr;
        memAddr   = hAddr;
        memWrData = hData;
        if (memReady) begin
          nAluOut    = hAddr;
          nSetVal    = hSetVal;
          nNextPc    = hNextPc;
          nRegWrt    = hRegWrt;
          nRegWrtSrc = hRegWrtSrc;
          nWriteReg  = hWriteReg;
          nHalt      = hHalt;
          nReadData  = hWr ? 16'h0000 : memRdData;
          nState     = hHalt ? S_HALT : S_IDLE;
        end else begin
          stall = 1'b1;
          if (waitCnt == TIMEOUT_LIM) begin
            internalErr = 1'b1;
            nHalt       = 1'b1;
            nState      = S_ERR;
          end else begin
            nWaitCnt = waitCnt + 8'd1;
          end
        end
      end

      S_HALT: begin
        nHalt = 1'b1;
      end

      S_ERR: begin
        nHalt = 1'b1;
      end

      default: begin
        nState = S_IDLE;
      end
    endcase
  end

  // State and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      waitCnt <= 8'd0;
    end else begin
      state   <= nState;
      waitCnt <= nWaitCnt;
    end
  end

  // Holding registers capture the instruction when it must wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hAddr      <= 16'h0000;
      hData      <= 16'h0000;
      hSetVal    <= 16'h0000;
      hNextPc    <= 16'h0000;
      hWr        <= 1'b0;
      hRegWrt    <= 1'b0;
      hHalt      <= 1'b0;
      hRegWrtSrc <= 3'd0;
      hWriteReg  <= 3'd0;
    end else if (captureHold) begin
      hAddr      <= aluOut;
      hData      <= reg2Data;
      hSetVal    <= setVal;
      hNextPc    <= nextPc;
      hWr        <= memWrt;
      hRegWrt    <= regWrt;
      hHalt      <= halt;
      hRegWrtSrc <= regWrtSrc;
      hWriteReg  <= writeReg;
    end
  end

  // MEM/WB pipeline register and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readDataOut  <= 16'h0000;
      aluOutOut    <= 16'h0000;
      setValOut    <= 16'h0000;
      nextPcOut    <= 16'h0000;
      regWrtOut    <= 1'b0;
      haltOut      <= 1'b0;
      regWrtSrcOut <= 3'd0;
      writeRegOut  <= 3'd0;
      err          <= 1'b0;
    end else begin
      readDataOut  <= nReadData;
      aluOutOut    <= nAluOut;
      setValOut    <= nSetVal;
      nextPcOut    <= nNextPc;
      regWrtOut    <= nRegWrt;
      haltOut      <= nHalt;
      regWrtSrcOut <= nRegWrtSrc;
      writeRegOut  <= nWriteReg;
      err          <= err | errIn | internalErr;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage

module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] aluOut = '0, reg2Data = '0, setVal = '0, nextPc = '0;
  logic        memEn = 1'b0, memWrt = 1'b0, regWrt = 1'b0;
  logic [2:0]  regWrtSrc = '0, writeReg = '0;
  logic        halt = 1'b0, errIn = 1'b0;
  logic        memReq, memWr;
  logic [15:0] memAddr, memWrData;
  logic [15:0] memRdData = '0;
  logic        memReady = 1'b0;
  logic        stall;
  logic [15:0] readDataOut, aluOutOut, setValOut, nextPcOut;
  logic        regWrtOut, haltOut, err;
  logic [2:0]  regWrtSrcOut, writeRegOut;

  int passed = 0;
  int total  = 0;

  // Memory contents as seen by the bench; unwritten words read a fixed pattern
  logic [15:0] mem [logic [15:0]];

  memory_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .aluOut(aluOut), .reg2Data(reg2Data), .setVal(setVal),
    .nextPc(nextPc), .memEn(memEn), .memWrt(memWrt), .regWrt(regWrt),
    .regWrtSrc(regWrtSrc), .writeReg(writeReg), .halt(halt), .errIn(errIn),
    .memReq(memReq), .memWr(memWr), .memAddr(memAddr), .memWrData(memWrData),
    .memRdData(memRdData), .memReady(memReady), .stall(stall),
    .readDataOut(readDataOut), .aluOutOut(aluOutOut), .setValOut(setValOut),
    .nextPcOut(nextPcOut), .regWrtOut(regWrtOut), .haltOut(haltOut), .err(err),
    .regWrtSrcOut(regWrtSrcOut), .writeRegOut(writeRegOut)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] memModel(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    memEn = 1'b0; memReady = 1'b0; halt = 1'b0; errIn = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One instruction; lat = number of cycles the memory withholds memReady
  task automatic doInstr(input logic en, input logic wr, input logic [15:0] addr,
                         input logic [15:0] data, input logic [15:0] sv,
                         input logic [15:0] pc, input logic rw, input logic [2:0] src,
                         input logic [2:0] wreg, input logic hl, input int lat);
    logic [15:0] expRd;
    expRd = (en && !wr) ? memModel(addr) : 16'h0000;
    memEn = en; memWrt = wr; aluOut = addr; reg2Data = data; setVal = sv;
    nextPc = pc; regWrt = rw; regWrtSrc = src; writeReg = wreg; halt = hl;
    memReady  = (lat == 0);
    memRdData = (lat == 0) ? memModel(addr) : 16'($urandom);
    #1;
    chk("reqIssue", 16'(memReq), 16'(en));
    chk("stallIssue", 16'(stall), 16'(en && lat > 0));
    if (en) begin
      chk("addrIssue", memAddr, addr);
      chk("wrDataIssue", memWrData, data);
      chk("wrIssue", 16'(memWr), 16'(wr));
    end
    for (int w = 1; w <= lat; w++) begin
      step();
      chk("bubbleRegWrt", 16'(regWrtOut), 16'h0);
      chk("bubbleHalt", 16'(haltOut), 16'h0);
      // Live inputs must be ignored while waiting
      aluOut = 16'($urandom); reg2Data = 16'($urandom); setVal = 16'($urandom);
      memWrt = 1'($urandom); regWrt = 1'($urandom); writeReg = 3'($urandom);
      memReady  = (w == lat);
      memRdData = (w == lat) ? memModel(addr) : 16'($urandom);
      #1;
      chk("reqWait", 16'(memReq), 16'h1);
      chk("addrWait", memAddr, addr);
      chk("wrDataWait", memWrData, data);
      chk("wrWait", 16'(memWr), 16'(wr));
      chk("stallWait", 16'(stall), 16'(w != lat));
    end
    step();
    if (en && wr) mem[addr] = data;
    chk("readData", readDataOut, expRd);
    chk("aluOutOut", aluOutOut, addr);
    chk("setValOut", setValOut, sv);
    chk("nextPcOut", nextPcOut, pc);
    chk("regWrtOut", 16'(regWrtOut), 16'(rw));
    chk("regWrtSrcOut", 16'(regWrtSrcOut), 16'(src));
    chk("writeRegOut", 16'(writeRegOut), 16'(wreg));
    chk("haltOut", 16'(haltOut), 16'(hl));
    memEn = 1'b0; memReady = 1'b0; halt = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    chk("rstReq", 16'(memReq), 16'h0);
    chk("rstStall", 16'(stall), 16'h0);
    chk("rstReadData", readDataOut, 16'h0);
    chk("rstAluOut", aluOutOut, 16'h0);
    chk("rstRegWrt", 16'(regWrtOut), 16'h0);
    chk("rstHalt", 16'(haltOut), 16'h0);
    chk("rstErr", 16'(err), 16'h0);
    rst = 1'b0;

    // Zero-wait read
    mem[16'h0040] = 16'hBEEF;
    doInstr(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1111, 16'h0102, 1'b1, 3'd1, 3'd2, 1'b0, 0);
    chk("zeroWaitData", readDataOut, 16'hBEEF);

    // Three-cycle write, then read it back
    doInstr(1'b1, 1'b1, 16'h0100, 16'h1234, 16'h2222, 16'h0104, 1'b0, 3'd2, 3'd3, 1'b0, 2);
    doInstr(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h3333, 16'h0106, 1'b1, 3'd1, 3'd4, 1'b0, 1);
    chk("readBack", readDataOut, 16'h1234);

    // Pass-through with no access
    doInstr(1'b0, 1'b0, 16'hA5A4, 16'hFFFF, 16'h4444, 16'h0108, 1'b1, 3'd5, 3'd6, 1'b0, 0);

    // Random instruction mix, wait latency up to the timeout boundary
    for (int i = 0; i < 40; i++) begin
      logic en, wr;
      int lat;
      en  = 1'($urandom);
      wr  = 1'($urandom);
      lat = en ? int'($urandom_range(0, 4)) : 0;
      doInstr(en, wr, 16'h0040 + 16'(2 * $urandom_range(0, 3)), 16'($urandom),
              16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
              1'b0, lat);
    end

    // Halt with pass-through, then halt is absorbing
    doInstr(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h5555, 16'h010A, 1'b1, 3'd0, 3'd1, 1'b1, 0);
    memEn = 1'b1; memWrt = 1'b0; aluOut = 16'h0040; regWrt = 1'b1; memReady = 1'b1;
    #1;
    chk("haltNoReq", 16'(memReq), 16'h0);
    chk("haltNoStall", 16'(stall), 16'h0);
    step();
    chk("haltStays", 16'(haltOut), 16'h1);
    chk("haltRegWrt", 16'(regWrtOut), 16'h0);
    chk("haltHoldsData", setValOut, 16'h5555);
    doReset();

    // Timeout: memory never answers
    memEn = 1'b1; memWrt = 1'b0; aluOut = 16'h0020; regWrt = 1'b1; memReady = 1'b0;
    #1;
    chk("toStallIdle", 16'(stall), 16'h1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("toReq", 16'(memReq), 16'h1);
      chk("toStall", 16'(stall), 16'h1);
      chk("toErrEarly", 16'(err), 16'h0);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      chk("toErr", 16'(err), 16'h1);
      chk("toHalt", 16'(haltOut), 16'h1);
      chk("toReq0", 16'(memReq), 16'h0);
      chk("toStall0", 16'(stall), 16'h0);
      chk("toRegWrt", 16'(regWrtOut), 16'h0);
      memReady = 1'b1;
      step();
    end
    doReset();
    chk("toCleared", 16'(err), 16'h0);

    // Asynchronous reset while waiting
    doInstr(1'b0, 1'b0, 16'h0ABC, 16'h0000, 16'h6666, 16'h0200, 1'b1, 3'd3, 3'd7, 1'b0, 0);
    memEn = 1'b1; memWrt = 1'b1; aluOut = 16'h0030; reg2Data = 16'h7777; memReady = 1'b0;
    step();
    step();
    memEn = 1'b0;
    #1;
    chk("waitStall", 16'(stall), 16'h1);
    chk("waitReq", 16'(memReq), 16'h1);
    rst = 1'b1;
    #1;
    chk("arstStall", 16'(stall), 16'h0);
    chk("arstReq", 16'(memReq), 16'h0);
    chk("arstAluOut", aluOutOut, 16'h0);
    chk("arstSetVal", setValOut, 16'h0);
    chk("arstWriteReg", 16'(writeRegOut), 16'h0);
    #1;
    rst = 1'b0;
    step();
    doInstr(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h8888, 16'h0202, 1'b1, 3'd1, 3'd1, 1'b0, 0);

    // Upstream error is sticky
    errIn = 1'b1;
    doInstr(1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0001, 16'h0204, 1'b0, 3'd0, 3'd0, 1'b0, 0);
    chk("errInSet", 16'(err), 16'h1);
    errIn = 1'b0;
    doInstr(1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0002, 16'h0206, 1'b1, 3'd0, 3'd0, 1'b0, 0);
    chk("errSticky", 16'(err), 16'h1);
    doReset();

    // Misaligned address
`ifdef MEM_ALIGN_CHECK_EN
    memEn = 1'b1; memWrt = 1'b0; aluOut = 16'h0041; memReady = 1'b1;
    #1;
    chk("misReq", 16'(memReq), 16'h0);
    step();
    chk("misErr", 16'(err), 16'h1);
    chk("misHalt", 16'(haltOut), 16'h1);
    doReset();
`else
    doInstr(1'b1, 1'b0, 16'h0041, 16'h0000, 16'h9999, 16'h0208, 1'b1, 3'd2, 3'd2, 1'b0, 0);
    chk("misNoErr", 16'(err), 16'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
